// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the MM:SS countdown timer.
//   state_t          : run/pause FSM state encoding (2 bits)
//   BCD_W            : width of one BCD digit
//   DIGIT_LIMIT_DEF  : reload value for 0..9 digits on borrow
//   SEC_T_LIMIT_DEF  : reload value for the seconds-tens digit on borrow
package countdown_timer_pkg;

   localparam int BCD_W = 4;

   localparam logic [BCD_W-1:0] DIGIT_LIMIT_DEF = 4'd9;
   localparam logic [BCD_W-1:0] SEC_T_LIMIT_DEF = 4'd5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/countdown_timer_down_counter.sv
// One BCD down-counting digit with combinational borrow-out.
//   clk, rst       : clock, asynchronous active-high reset (to value_initial)
//   load           : synchronous reload of value_initial (beats decrease)
//   decrease       : count down by one this cycle
//   limit          : value taken when decrementing through zero
//   value_initial  : reset/load value
//   value          : current digit (registered)
//   borrow         : high when this digit wraps, i.e. the next digit must decrease
module down_counter
   import countdown_timer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             decrease,
   input  logic [BCD_W-1:0] limit,
   input  logic [BCD_W-1:0] value_initial,
   output logic [BCD_W-1:0] value,
   output logic             borrow
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= value_initial;
      end else if (load) begin
         value <= value_initial;
      end else if (decrease) begin
         if (value == '0) value <= limit;
         else             value <= value - 1'b1;
      end
   end

   // Borrow is combinational so the whole chain settles within one cycle.
   assign borrow = decrease && (value == '0);

endmodule

// File: rtl/countdown_timer.sv
// Four-digit BCD MM:SS countdown timer with run/pause/done control.
//   clk, rst     : clock, asynchronous active-high reset
//   tick         : one-cycle count enable (1 Hz)
//   start_pause  : one-cycle pulse toggling run/pause (starts from idle)
//   load         : one-cycle pulse restoring INIT_* digits and returning to idle
//   min_tens, min_ones, sec_tens, sec_ones : BCD digits
//   running      : high while counting is enabled
//   done         : high once 00:00 has been reached
//   timeout      : one-cycle pulse when done rises
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter logic [3:0] INIT_MT     = 4'd0,
   parameter logic [3:0] INIT_MO     = 4'd1,
   parameter logic [3:0] INIT_ST     = 4'd3,
   parameter logic [3:0] INIT_SO     = 4'd0,
   parameter logic [3:0] SEC_T_LIMIT = SEC_T_LIMIT_DEF,
   parameter logic [3:0] DIGIT_LIMIT = DIGIT_LIMIT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             start_pause,
   input  logic             load,
   output logic [BCD_W-1:0] min_tens,
   output logic [BCD_W-1:0] min_ones,
   output logic [BCD_W-1:0] sec_tens,
   output logic [BCD_W-1:0] sec_ones,
   output logic             running,
   output logic             done,
   output logic             timeout
);

   state_t state;

   logic dec_so;
   logic borrow_so, borrow_st, borrow_mo, borrow_mt;
   logic is_zero, is_one;

   // Only the seconds-ones digit is enabled directly; the rest ride the borrow chain.
   assign dec_so = (state == S_RUN) && tick && !load;

   down_counter u_sec_ones (
      .clk           (clk),
      .rst           (rst),
      .load          (load),
      .decrease      (dec_so),
      .limit         (DIGIT_LIMIT),
      .value_initial (INIT_SO),
      .value         (sec_ones),
      .borrow        (borrow_so)
   );

   down_counter u_sec_tens (
      .clk           (clk),
      .rst           (rst),
      .load          (load),
      .decrease      (borrow_so),
      .limit         (SEC_T_LIMIT),
      .value_initial (INIT_ST),
      .value         (sec_tens),
      .borrow        (borrow_st)
   );

   down_counter u_min_ones (
      .clk           (clk),
      .rst           (rst),
      .load          (load),
      .decrease      (borrow_st),
      .limit         (DIGIT_LIMIT),
      .value_initial (INIT_MO),
      .value         (min_ones),
      .borrow        (borrow_mo)
   );

   down_counter u_min_tens (
      .clk           (clk),
      .rst           (rst),
      .load          (load),
      .decrease      (borrow_mo),
      .limit         (DIGIT_LIMIT),
      .value_initial (INIT_MT),
      .value         (min_tens),
      .borrow        (borrow_mt)
   );

   // RUN is left before the display can reach 00:00 and tick again, so the
   // top digit can never borrow; flag it if that invariant is ever broken.
   always_comb begin
      assert (!borrow_mt);
   end

   assign is_zero = (min_tens == '0) && (min_ones == '0) &&
                    (sec_tens == '0) && (sec_ones == '0);
   assign is_one  = (min_tens == '0) && (min_ones == '0) &&
                    (sec_tens == '0) && (sec_ones == 4'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         running <= 1'b0;
         done    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         timeout <= 1'b0;
         if (load) begin
            state   <= S_IDLE;
            running <= 1'b0;
            done    <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start_pause) begin
                     if (is_zero) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                     end else begin
                        state   <= S_RUN;
                        running <= 1'b1;
                     end
                  end
               end
               S_RUN: begin
                  // Reaching 00:00 wins over a simultaneous pause request so
                  // the timer can never sit paused at zero.
                  if (tick && is_one) begin
                     state   <= S_DONE;
                     running <= 1'b0;
                     done    <= 1'b1;
                     timeout <= 1'b1;
                  end else if (start_pause) begin
                     state   <= S_PAUSE;
                     running <= 1'b0;
                  end
               end
               S_PAUSE: begin
                  if (start_pause) begin
                     state   <= S_RUN;
                     running <= 1'b1;
                  end
               end
               S_DONE: begin
                  state <= S_DONE;
               end
               default: begin
                  state   <= S_IDLE;
                  running <= 1'b0;
                  done    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed bench for countdown_timer against a seconds-count model.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       start_pause = 1'b0;
   logic       load = 1'b0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       running, done, timeout;

   logic       z_sp = 1'b0;
   logic       z_load = 1'b0;
   logic [3:0] z_mt, z_mo, z_st, z_so;
   logic       z_running, z_done, z_timeout;

   int n_checks = 0;
   int n_errors = 0;

   // Model: remaining time as a plain number of seconds plus a mode.
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
   localparam int INIT_SECS = 90;
   int m_secs = INIT_SECS;
   int m_mode = M_IDLE;
   bit m_to   = 1'b0;

   countdown_timer dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .start_pause (start_pause),
      .load        (load),
      .min_tens    (min_tens),
      .min_ones    (min_ones),
      .sec_tens    (sec_tens),
      .sec_ones    (sec_ones),
      .running     (running),
      .done        (done),
      .timeout     (timeout)
   );

   countdown_timer #(
      .INIT_MT (4'd0), .INIT_MO (4'd0), .INIT_ST (4'd0), .INIT_SO (4'd0)
   ) dut_z (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .start_pause (z_sp),
      .load        (z_load),
      .min_tens    (z_mt),
      .min_ones    (z_mo),
      .sec_tens    (z_st),
      .sec_ones    (z_so),
      .running     (z_running),
      .done        (z_done),
      .timeout     (z_timeout)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_digits(input int secs);
      int mins;
      mins = secs / 60;
      return {4'(mins / 10), 4'(mins % 10), 4'((secs % 60) / 10), 4'(secs % 10)};
   endfunction

   task automatic check_all(input string tag);
      check_eq({tag, ".digits"}, {16'd0, min_tens, min_ones, sec_tens, sec_ones},
               {16'd0, exp_digits(m_secs)});
      check_eq({tag, ".running"}, {31'd0, running}, {31'd0, m_mode == M_RUN});
      check_eq({tag, ".done"}, {31'd0, done}, {31'd0, m_mode == M_DONE});
      check_eq({tag, ".timeout"}, {31'd0, timeout}, {31'd0, m_to});
   endtask

   task automatic model_step(input bit t, input bit sp, input bit ld);
      m_to = 1'b0;
      if (ld) begin
         m_secs = INIT_SECS;
         m_mode = M_IDLE;
      end else begin
         case (m_mode)
            M_IDLE: if (sp) begin
               if (m_secs == 0) begin m_mode = M_DONE; m_to = 1'b1; end
               else m_mode = M_RUN;
            end
            M_RUN: begin
               if (t) m_secs = m_secs - 1;
               if (m_secs == 0) begin m_mode = M_DONE; m_to = 1'b1; end
               else if (sp) m_mode = M_PAUSE;
            end
            M_PAUSE: if (sp) m_mode = M_RUN;
            default: ;
         endcase
      end
   endtask

   // Apply inputs for one clock, advance the model, then check just after the edge.
   task automatic cycle(input bit t, input bit sp, input bit ld, input string tag);
      tick = t;
      start_pause = sp;
      load = ld;
      @(posedge clk);
      model_step(t, sp, ld);
      #1;
      tick = 1'b0;
      start_pause = 1'b0;
      load = 1'b0;
      check_all(tag);
   endtask

   task automatic ticks(input int n, input string tag);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, tag);
   endtask

   initial begin
      // Reset state
      #12;
      check_all("reset");
      check_eq("z_reset.done", {31'd0, z_done}, 32'd0);
      rst = 1'b0;

      ticks(5, "idle_ticks");
      cycle(1'b0, 1'b1, 1'b0, "start");
      ticks(1, "first_tick");
      ticks(9, "to_0120");
      ticks(20, "to_0100");
      ticks(1, "borrow_0059");
      ticks(57, "to_0002");
      ticks(1, "to_0001");
      ticks(1, "to_0000");
      ticks(1, "after_timeout");
      cycle(1'b1, 1'b1, 1'b0, "done_ignore_sp");
      ticks(3, "done_hold");

      cycle(1'b0, 1'b0, 1'b1, "load_from_done");
      cycle(1'b0, 1'b1, 1'b0, "start2");
      ticks(45, "to_0045");
      cycle(1'b0, 1'b1, 1'b0, "pause");
      ticks(3, "pause_hold");
      cycle(1'b1, 1'b1, 1'b0, "resume_with_tick");
      ticks(1, "to_0044");
      ticks(34, "to_0010");
      cycle(1'b1, 1'b1, 1'b1, "load_priority");

      // Async reset between edges while running
      cycle(1'b0, 1'b1, 1'b0, "start3");
      ticks(7, "run_before_rst");
      #3 rst = 1'b1;
      #1;
      m_secs = INIT_SECS; m_mode = M_IDLE; m_to = 1'b0;
      check_all("async_rst");
      #2 rst = 1'b0;

      // 00:00 initial values: start goes straight to DONE
      check_eq("z_pre.done", {31'd0, z_done}, 32'd0);
      z_sp = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, "z_start");
      z_sp = 1'b0;
      check_eq("z_start.done", {31'd0, z_done}, 32'd1);
      check_eq("z_start.timeout", {31'd0, z_timeout}, 32'd1);
      check_eq("z_start.running", {31'd0, z_running}, 32'd0);
      check_eq("z_start.digits", {16'd0, z_mt, z_mo, z_st, z_so}, 32'd0);
      cycle(1'b1, 1'b0, 1'b0, "z_after");
      check_eq("z_after.timeout", {31'd0, z_timeout}, 32'd0);
      check_eq("z_after.done", {31'd0, z_done}, 32'd1);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         bit t, sp, ld;
         t  = ($urandom_range(0, 1) == 1);
         sp = ($urandom_range(0, 15) == 0);
         ld = (m_mode == M_DONE) ? ($urandom_range(0, 7) == 0)
                                 : ($urandom_range(0, 299) == 0);
         cycle(t, sp, ld, "random");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
